// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle spawner: game states, obstacle kinds,
// spawner FSM states and the LFSR feedback mask.
package obstacle_pkg;

    typedef enum logic [1:0] {
        UNBEGIN = 2'b00,
        RUNNING = 2'b01,
        DEAD    = 2'b10
    } gamestate_e;

    typedef enum logic [1:0] {
        KIND_SMALL  = 2'd0,
        KIND_MEDIUM = 2'd1,
        KIND_BIG    = 2'd2,
        KIND_BIRD   = 2'd3
    } obs_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COUNT = 3'd2,
        ST_ARM   = 3'd3,
        ST_WAIT  = 3'd4
    } spawn_state_e;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int          GAP_W     = 12;

endpackage

// File: rtl/spawn_lfsr.sv
// 16-bit Galois LFSR (right-shifting, feedback mask LFSR_MASK) with step enable
// and a parameterised nonzero reset seed.
module spawn_lfsr
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] r_lfsr;
    logic [15:0] w_next;

    assign w_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= w_next;
        end
    end

    assign o_state = r_lfsr;

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: paces spawns with an LFSR-randomised gap and hands each one to the
// lowest free drawer slot. Optional feature macro: SPAWN_BIRD_EN (bird kind at level>=1).
module obstacle_spawner
    import obstacle_pkg::*;
#(
    parameter int          NUM_SLOTS      = 2,
    parameter int          MIN_GAP        = 200,
    parameter int          GAP_RANGE_BITS = 8,
    parameter int          SPAWNS_PER_LVL = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
)
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_step_en,
    input  logic [1:0]           i_gamestate,
    input  logic [NUM_SLOTS-1:0] i_slot_busy,
    output logic [NUM_SLOTS-1:0] o_spawn,
    output logic [1:0]           o_spawn_kind,
    output logic [1:0]           o_level,
    output spawn_state_e         o_dbg_state,
    output logic [GAP_W-1:0]     o_dbg_gap_cnt,
    output logic [15:0]          o_dbg_lfsr
);

    localparam int CNT_W = (SPAWNS_PER_LVL > 1) ? $clog2(SPAWNS_PER_LVL) : 1;

    if ((MIN_GAP + (1 << GAP_RANGE_BITS) - 1 > (1 << GAP_W) - 1) || (MIN_GAP < 1) ||
        (GAP_RANGE_BITS < 1) || (GAP_RANGE_BITS > 10) || (NUM_SLOTS < 1) || (NUM_SLOTS > 4) ||
        (SPAWNS_PER_LVL < 1) || (LFSR_SEED == 16'h0000)) begin : g_bad_params
        $error("obstacle_spawner: illegal parameter combination (gap overflow or out of range)");
    end

    // Spawn interface: o_spawn is a one-hot, single-cycle request with o_spawn_kind valid in the
    // same cycle; there is no ready. The drawer acknowledges implicitly by raising i_slot_busy.

    logic                 w_running;
    logic                 w_dead;
    logic [15:0]          w_lfsr;
    logic [NUM_SLOTS-1:0] w_free;
    logic [NUM_SLOTS-1:0] w_pick;
    logic [GAP_W-1:0]     w_rand_term;
    logic [GAP_W-1:0]     w_gap_load;
    obs_kind_e            w_kind_draw;

    spawn_state_e         r_state;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [NUM_SLOTS-1:0] r_pending;
    logic [NUM_SLOTS-1:0] r_spawn;
    obs_kind_e            r_kind;
    logic [1:0]           r_level;
    logic [CNT_W-1:0]     r_spawn_cnt;

    spawn_state_e         w_state_nxt;
    logic [GAP_W-1:0]     w_gap_nxt;
    logic [NUM_SLOTS-1:0] w_pending_nxt;
    logic [NUM_SLOTS-1:0] w_spawn_nxt;
    obs_kind_e            w_kind_nxt;
    logic [1:0]           w_level_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    assign w_running = (i_gamestate == RUNNING);
    assign w_dead    = (i_gamestate == DEAD);

    spawn_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_step_en & w_running),
        .o_state (w_lfsr)
    );

    // Lowest set bit of the free mask via two's-complement isolation.
    assign w_free      = ~i_slot_busy & ~r_pending;
    assign w_pick      = w_free & (~w_free + NUM_SLOTS'(1));
    assign w_rand_term = GAP_W'(w_lfsr[GAP_RANGE_BITS-1:0]) >> r_level;
    assign w_gap_load  = GAP_W'(MIN_GAP) + w_rand_term;

    always_comb begin
        w_kind_draw = obs_kind_e'(w_lfsr[1:0]);
`ifdef SPAWN_BIRD_EN
        if (w_lfsr[1:0] == 2'd3 && r_level == 2'd0) begin
            w_kind_draw = KIND_BIG;
        end
`else
        if (w_lfsr[1:0] == 2'd3) begin
            w_kind_draw = KIND_SMALL;
        end
`endif
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gap_nxt     = r_gap_cnt;
        w_pending_nxt = r_pending;
        w_spawn_nxt   = '0;
        w_kind_nxt    = r_kind;
        w_level_nxt   = r_level;
        w_cnt_nxt     = r_spawn_cnt;
        if (w_dead) begin
            // Frozen in place; only outstanding requests are forgotten.
            w_pending_nxt = '0;
        end else if (!w_running) begin
            w_state_nxt   = ST_IDLE;
            w_gap_nxt     = '0;
            w_pending_nxt = '0;
            w_level_nxt   = '0;
            w_cnt_nxt     = '0;
        end else begin
            w_pending_nxt = r_pending & ~i_slot_busy;
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    w_gap_nxt   = w_gap_load;
                    w_state_nxt = ST_COUNT;
                end
                ST_COUNT: begin
                    if (i_step_en) begin
                        w_gap_nxt = r_gap_cnt - GAP_W'(1);
                        if (r_gap_cnt == GAP_W'(1)) begin
                            w_state_nxt = ST_ARM;
                        end
                    end
                end
                ST_ARM, ST_WAIT: begin
                    if (|w_free) begin
                        w_spawn_nxt   = w_pick;
                        w_kind_nxt    = w_kind_draw;
                        w_pending_nxt = (r_pending & ~i_slot_busy) | w_pick;
                        w_state_nxt   = ST_LOAD;
                        if (r_spawn_cnt == CNT_W'(SPAWNS_PER_LVL - 1)) begin
                            w_cnt_nxt = '0;
                            if (r_level != 2'd3) begin
                                w_level_nxt = r_level + 2'd1;
                            end
                        end else begin
                            w_cnt_nxt = r_spawn_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_gap_cnt   <= '0;
            r_pending   <= '0;
            r_spawn     <= '0;
            r_kind      <= KIND_SMALL;
            r_level     <= '0;
            r_spawn_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_pending   <= w_pending_nxt;
            r_spawn     <= w_spawn_nxt;
            r_kind      <= w_kind_nxt;
            r_level     <= w_level_nxt;
            r_spawn_cnt <= w_cnt_nxt;
        end
    end

    assign o_spawn       = w_running ? r_spawn : '0;
    assign o_spawn_kind  = r_kind;
    assign o_level       = r_level;
    assign o_dbg_state   = r_state;
    assign o_dbg_gap_cnt = r_gap_cnt;
    assign o_dbg_lfsr    = w_lfsr;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed self-checking bench for obstacle_spawner (MIN_GAP=8, GAP_RANGE_BITS=2, 2 slots,
// 2 spawns per level); build with SPAWN_BIRD_EN defined to cover the bird variant.
module tb_obstacle_spawner;
    import obstacle_pkg::*;

    localparam int          NS   = 2;
    localparam int          MING = 8;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          LIM  = 60;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          step_en   = 1'b0;
    logic [1:0]    gamestate = 2'b00;
    logic [NS-1:0] slot_busy = '0;
    logic [NS-1:0] spawn;
    logic [1:0]    spawn_kind;
    logic [1:0]    level;
    spawn_state_e  dbg_state;
    logic [11:0]   dbg_gap;
    logic [15:0]   dbg_lfsr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_lfsr   = SEED;

    obstacle_spawner #(
        .NUM_SLOTS      (NS),
        .MIN_GAP        (MING),
        .GAP_RANGE_BITS (2),
        .SPAWNS_PER_LVL (2),
        .LFSR_SEED      (SEED)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_step_en     (step_en),
        .i_gamestate   (gamestate),
        .i_slot_busy   (slot_busy),
        .o_spawn       (spawn),
        .o_spawn_kind  (spawn_kind),
        .o_level       (level),
        .o_dbg_state   (dbg_state),
        .o_dbg_gap_cnt (dbg_gap),
        .o_dbg_lfsr    (dbg_lfsr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
        logic [15:0] t;
        t = s;
        for (int i = 0; i < n; i++) t = lfsr_step(t);
        return t;
    endfunction

    function automatic logic [1:0] map_kind(input logic [1:0] d, input logic [1:0] lvl);
`ifdef SPAWN_BIRD_EN
        return (d == 2'd3 && lvl == 2'd0) ? 2'd2 : d;
`else
        return (d == 2'd3) ? 2'd0 : d;
`endif
    endfunction

    function automatic int gap_of(input logic [15:0] m, input logic [1:0] lvl);
        return MING + (int'(m[1:0]) >> lvl);
    endfunction

    function automatic logic [1:0] kind_at(input logic [15:0] m, input int n, input logic [1:0] lvl);
        logic [15:0] t;
        t = lfsr_adv(m, n);
        return map_kind(t[1:0], lvl);
    endfunction

    function automatic logic [1:0] lvl_after(input int spawns);
        return (spawns / 2 > 3) ? 2'd3 : 2'(spawns / 2);
    endfunction

    // One clock: model LFSR follows the inputs seen at the edge; returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) m_lfsr = SEED;
        else if (step_en && gamestate == 2'b01) m_lfsr = lfsr_step(m_lfsr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; step_en = 1'b0; gamestate = 2'b00; slot_busy = '0; m_lfsr = SEED;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (spawn !== 2'b00) begin n_fail++; $display("FAIL reset_spawn: got %b want 00", spawn); end
        n_checks++; if (spawn_kind !== 2'd0) begin n_fail++; $display("FAIL reset_kind: got %0d want 0", spawn_kind); end
        n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_checks++; if (dbg_gap !== 12'd0) begin n_fail++; $display("FAIL reset_gap: got %0d want 0", dbg_gap); end
        n_checks++; if (dbg_lfsr !== SEED) begin n_fail++; $display("FAIL reset_lfsr: got %h want %h", dbg_lfsr, SEED); end
    endtask

    task automatic test_first_spawn();
        int g, n;
        logic [15:0] l1;
        do_reset();
        gamestate = 2'b01; step_en = 1'b1;
        l1 = lfsr_step(SEED); g = gap_of(l1, 2'd0);
        n = 0;
        do begin tick(); n++; end while (spawn === '0 && n < LIM);
        n_checks++; if (n !== g + 3) begin n_fail++; $display("FAIL first_latency: got %0d want %0d", n, g + 3); end
        n_checks++; if (spawn !== 2'b01) begin n_fail++; $display("FAIL first_slot: got %b want 01", spawn); end
        n_checks++; if (spawn_kind !== kind_at(l1, g + 1, 2'd0)) begin n_fail++; $display("FAIL first_kind: got %0d want %0d", spawn_kind, kind_at(l1, g + 1, 2'd0)); end
        n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL first_level: got %0d want 0", level); end
        n_checks++; if (dbg_lfsr !== m_lfsr) begin n_fail++; $display("FAIL first_lfsr: got %h want %h", dbg_lfsr, m_lfsr); end
        tick();
        n_checks++; if (spawn !== 2'b00) begin n_fail++; $display("FAIL pulse_width: got %b want 00", spawn); end
    endtask

    task automatic test_level_chain();
        int g, n, pred;
        logic [15:0] l1;
        logic [1:0]  exp_kind, lvl;
        do_reset();
        gamestate = 2'b01; step_en = 1'b1;
        l1 = lfsr_step(SEED); g = gap_of(l1, 2'd0);
        pred = g + 3; exp_kind = kind_at(l1, g + 1, 2'd0);
        for (int k = 1; k <= 8; k++) begin
            n = 0;
            do begin
                tick(); n++;
                slot_busy = '0;
            end while (spawn === '0 && n < LIM);
            n_checks++; if (n !== pred) begin n_fail++; $display("FAIL chain_latency[%0d]: got %0d want %0d", k, n, pred); end
            n_checks++; if (spawn !== 2'b01) begin n_fail++; $display("FAIL chain_slot[%0d]: got %b want 01", k, spawn); end
            n_checks++; if (spawn_kind !== exp_kind) begin n_fail++; $display("FAIL chain_kind[%0d]: got %0d want %0d", k, spawn_kind, exp_kind); end
            n_checks++; if (level !== lvl_after(k)) begin n_fail++; $display("FAIL chain_level[%0d]: got %0d want %0d", k, level, lvl_after(k)); end
            if (n >= LIM) return;
            slot_busy = spawn;
            lvl = lvl_after(k);
            g = gap_of(m_lfsr, lvl);
            pred = g + 2; exp_kind = kind_at(m_lfsr, g + 1, lvl);
        end
    endtask

    task automatic test_slot_select();
        int g, n, seen;
        logic [15:0] l1, mp;
        do_reset();
        slot_busy = 2'b01; gamestate = 2'b01; step_en = 1'b1;
        l1 = lfsr_step(SEED); g = gap_of(l1, 2'd0);
        n = 0;
        do begin tick(); n++; end while (spawn === '0 && n < LIM);
        n_checks++; if (n !== g + 3) begin n_fail++; $display("FAIL slot_latency: got %0d want %0d", n, g + 3); end
        n_checks++; if (spawn !== 2'b10) begin n_fail++; $display("FAIL slot_skip_busy: got %b want 10", spawn); end
        n_checks++; if (spawn_kind !== kind_at(l1, g + 1, 2'd0)) begin n_fail++; $display("FAIL slot_kind: got %0d want %0d", spawn_kind, kind_at(l1, g + 1, 2'd0)); end
        slot_busy = 2'b11; seen = 0;
        repeat (20) begin tick(); if (spawn !== '0) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL wait_no_spawn: got %0d pulses want 0", seen); end
        n_checks++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL wait_state: got %0d want %0d", dbg_state, ST_WAIT); end
        slot_busy = 2'b10; mp = m_lfsr;
        tick();
        n_checks++; if (spawn !== 2'b01) begin n_fail++; $display("FAIL wait_release: got %b want 01", spawn); end
        n_checks++; if (spawn_kind !== map_kind(mp[1:0], 2'd0)) begin n_fail++; $display("FAIL wait_kind: got %0d want %0d", spawn_kind, map_kind(mp[1:0], 2'd0)); end
        n_checks++; if (level !== 2'd1) begin n_fail++; $display("FAIL wait_level: got %0d want 1", level); end
    endtask

    task automatic test_dead_freeze();
        int g, n, seen;
        logic [15:0] l1, mr;
        do_reset();
        gamestate = 2'b01; step_en = 1'b1;
        l1 = lfsr_step(SEED); g = gap_of(l1, 2'd0);
        repeat (5) tick();
        n_checks++; if (dbg_gap !== 12'(g - 3)) begin n_fail++; $display("FAIL dead_pre_gap: got %0d want %0d", dbg_gap, g - 3); end
        gamestate = 2'b10; seen = 0;
        repeat (50) begin tick(); if (spawn !== '0) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL dead_no_spawn: got %0d pulses want 0", seen); end
        n_checks++; if (dbg_gap !== 12'(g - 3)) begin n_fail++; $display("FAIL dead_gap_frozen: got %0d want %0d", dbg_gap, g - 3); end
        n_checks++; if (dbg_state !== ST_COUNT) begin n_fail++; $display("FAIL dead_state_frozen: got %0d want %0d", dbg_state, ST_COUNT); end
        n_checks++; if (dbg_lfsr !== m_lfsr) begin n_fail++; $display("FAIL dead_lfsr_frozen: got %h want %h", dbg_lfsr, m_lfsr); end
        gamestate = 2'b01; mr = m_lfsr;
        n = 0;
        do begin tick(); n++; end while (spawn === '0 && n < LIM);
        n_checks++; if (n !== g - 2) begin n_fail++; $display("FAIL resume_latency: got %0d want %0d", n, g - 2); end
        n_checks++; if (spawn_kind !== kind_at(mr, g - 3, 2'd0)) begin n_fail++; $display("FAIL resume_kind: got %0d want %0d", spawn_kind, kind_at(mr, g - 3, 2'd0)); end
    endtask

    task automatic test_abort_in_arm();
        int g;
        do_reset();
        gamestate = 2'b01; step_en = 1'b1;
        g = gap_of(lfsr_step(SEED), 2'd0);
        repeat (g + 2) tick();
        n_checks++; if (dbg_state !== ST_ARM) begin n_fail++; $display("FAIL abort_at_arm: got %0d want %0d", dbg_state, ST_ARM); end
        gamestate = 2'b00;
        tick();
        n_checks++; if (spawn !== 2'b00) begin n_fail++; $display("FAIL abort_no_spawn: got %b want 00", spawn); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_idle: got %0d want %0d", dbg_state, ST_IDLE); end
        gamestate = 2'b11;
        tick();
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL gs11_idle: got %0d want %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_rst_mid();
        int g, n;
        do_reset();
        gamestate = 2'b01; step_en = 1'b1;
        g = gap_of(lfsr_step(SEED), 2'd0);
        repeat (6) tick();
        rst = 1'b1;
        #1;
        n_checks++; if (spawn !== 2'b00) begin n_fail++; $display("FAIL rst_spawn: got %b want 00", spawn); end
        n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", level); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_checks++; if (dbg_lfsr !== SEED) begin n_fail++; $display("FAIL rst_lfsr: got %h want %h", dbg_lfsr, SEED); end
        tick();
        rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (spawn === '0 && n < LIM);
        n_checks++; if (n !== g + 3) begin n_fail++; $display("FAIL rst_restart_latency: got %0d want %0d", n, g + 3); end
        rst = 1'b1;
        #1;
        n_checks++; if (spawn !== 2'b00) begin n_fail++; $display("FAIL rst_inflight_drop: got %b want 00", spawn); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_bird();
        int g, n, pred, bad, illegal, done;
        logic [15:0] l1;
        logic [1:0]  exp_kind, lvl;
        do_reset();
        gamestate = 2'b01; step_en = 1'b1;
        l1 = lfsr_step(SEED); g = gap_of(l1, 2'd0);
        pred = g + 3; exp_kind = kind_at(l1, g + 1, 2'd0); lvl = 2'd0;
        bad = 0; illegal = 0; done = 0;
        for (int k = 1; k <= 200; k++) begin
            n = 0;
            do begin
                tick(); n++;
                slot_busy = '0;
            end while (spawn === '0 && n < LIM);
            if (n !== pred || spawn !== 2'b01 || spawn_kind !== exp_kind) bad++;
`ifdef SPAWN_BIRD_EN
            if (spawn_kind === 2'd3 && lvl == 2'd0) illegal++;
`else
            if (spawn_kind === 2'd3) illegal++;
`endif
            done = k;
            if (n >= LIM) break;
            slot_busy = spawn;
            lvl = lvl_after(k);
            g = gap_of(m_lfsr, lvl);
            pred = g + 2; exp_kind = kind_at(m_lfsr, g + 1, lvl);
        end
        n_checks++; if (done !== 200) begin n_fail++; $display("FAIL bird_spawn_count: got %0d want 200", done); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bird_model_match: got %0d deviating spawns want 0", bad); end
        n_checks++; if (illegal !== 0) begin n_fail++; $display("FAIL bird_kind_rule: got %0d illegal bird kinds want 0", illegal); end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_level_chain();
        test_slot_select();
        test_dead_freeze();
        test_abort_in_arm();
        test_rst_mid();
        test_bird();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
